// File: rtl/core_mc.sv
// core_mc -- multicycle RV64I-subset core (add/sub/and/or/sll/srl, addi, ld, sd, beq).
//
// One FSM walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. Instruction and
// data memories live outside the core; each is reached through a req/ack handshake.
//
// Handshake (both memory ports): the core raises req together with addr/we/wdata and
// holds all of them stable until the cycle in which ack=1 (ack may come in the first
// req cycle). The transfer completes on that clock edge and req drops in the next
// cycle. ack while req=0 is ignored.
//
// Optional feature: define CORE_MC_PERF_EN to add the perf_cycle / perf_instret
// counters and their output ports.
//
// Ports:
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   imem_req/addr/ack/rdata instruction fetch port (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata  data port (addr = ALU result, wdata = rs2)
//   halt                   sticky, set when an illegal instruction is decoded
//   perf_cycle/instret     (CORE_MC_PERF_EN only) cycle and retire counters
module core_mc #(
  parameter int              XLEN     = 64,
  parameter int              PC_W     = 12,
  parameter int              DADDR_W  = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               halt
`ifdef CORE_MC_PERF_EN
  ,
  output logic [63:0]        perf_cycle,
  output logic [63:0]        perf_instret
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [XLEN-1:0]   a_q, b_q, imm_q, alu_q, mdr_q;
  logic [XLEN-1:0]   regs [0:31];

  logic              fetch_req, data_req, retire;

  // ---------------------------------------------------------------- decode
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       is_r, is_addi, is_ld, is_sd, is_beq, r_legal, legal;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_r    = (opcode == OP_R);
  assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
  assign is_ld   = (opcode == OP_LOAD)   && (funct3 == 3'b011);
  assign is_sd   = (opcode == OP_STORE)  && (funct3 == 3'b011);
  assign is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);

  // Only add/sub/sll/srl/or/and are implemented in the R group.
  always_comb begin
    r_legal = 1'b0;
    if (funct7 == 7'b0000000) begin
      r_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    end else if (funct7 == 7'b0100000) begin
      r_legal = (funct3 == 3'b000);
    end
  end

  assign legal = (is_r && r_legal) || is_addi || is_ld || is_sd || is_beq;

  // ------------------------------------------------------- immediate gen
  logic [XLEN-1:0] imm_gen;
  always_comb begin
    imm_gen = '0;
    case (opcode)
      OP_IMM, OP_LOAD: imm_gen = {{(XLEN-12){ir[31]}}, ir[31:20]};
      OP_STORE:        imm_gen = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:       imm_gen = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25],
                                  ir[11:8], 1'b0};
      default:         imm_gen = '0;
    endcase
  end

  // ------------------------------------------------------- register read
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // ------------------------------------------------------------------ ALU
  logic [XLEN-1:0] alu_b, alu_res;
  logic [5:0]      shamt;
  always_comb begin
    alu_b   = is_r ? b_q : imm_q;
    shamt   = (XLEN == 64) ? alu_b[5:0] : {1'b0, alu_b[4:0]};
    alu_res = a_q + alu_b;               // addi, ld/sd address, R add
    if (is_r) begin
      case ({funct7[5], funct3})
        4'b1_000: alu_res = a_q - alu_b;
        4'b0_001: alu_res = a_q << shamt;
        4'b0_101: alu_res = a_q >> shamt;
        4'b0_110: alu_res = a_q | alu_b;
        4'b0_111: alu_res = a_q & alu_b;
        default:  alu_res = a_q + alu_b;
      endcase
    end
  end

  // ------------------------------------------------------- PC arithmetic
  logic [PC_W-1:0] pc_plus4, pc_br;
  always_comb begin
    pc_plus4   = pc + PC_W'(4);
    pc_br      = pc + imm_q[PC_W-1:0];
    pc_br[1:0] = 2'b00;
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_beq) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end else if (is_ld || is_sd) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        data_req = 1'b1;
        if (dmem_ack) begin
          state_nx = is_ld ? S_WB : S_FETCH;
          retire   = !is_ld;
        end
      end
      S_WB: begin
        state_nx = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  // The FSM sits in FETCH during reset; gating with rstn keeps both requests low
  // for as long as reset is held.
  assign imem_req   = fetch_req && rstn;
  assign imem_addr  = pc;
  assign dmem_req   = data_req && rstn;
  assign dmem_we    = dmem_req && is_sd;
  assign dmem_addr  = alu_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign halt       = (state == S_HALT);

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc    <= RESET_PC;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_gen;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (is_beq) pc <= (a_q == b_q) ? pc_br : pc_plus4;
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_ld) mdr_q <= dmem_rdata;
            else       pc    <= pc_plus4;
          end
        end
        S_WB:    pc <= pc_plus4;
        default: ;
      endcase
    end
  end

  // Register file; x0 is never written so it reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == S_WB && rd != 5'd0) begin
      regs[rd] <= is_ld ? mdr_q : alu_q;
    end
  end

`ifdef CORE_MC_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      if (!halt) perf_cycle   <= perf_cycle + 64'd1;
      if (retire) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mc.sv
// Self-checking bench for core_mc (XLEN=64, PC_W=12, RESET_PC=0x040).
// A bench-side memory model serves both ports with configurable wait states and
// drives stray acks while req=0. Expected bus events (fetch address + cycles since
// previous fetch, store address/data, load address) are queued up front; a monitor
// pops and compares whenever a handshake completes.
module tb_core_mc;
  localparam int W = 78;  // {kind[1:0], addr[11:0], data[63:0]}

  // ---------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [11:0] dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic        halt;
`ifdef CORE_MC_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  core_mc #(.XLEN(64), .PC_W(12), .DADDR_W(12), .RESET_PC(12'h040)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halt(halt)
`ifdef CORE_MC_PERF_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ------------------------------------------------------ instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), 3'd3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'd0, im[4:1], im[11], 7'h63};
  endfunction

  // ------------------------------------------------------------ memory model
  logic [31:0] rom  [0:1023];
  logic [63:0] dram [0:511];
  int iwait = 0;
  int dwait = 2;
  bit stray_en = 1'b0;
  bit tog = 1'b0;
  int icnt = 0;
  int dcnt = 0;

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (imem_req) begin
        imem_ack   = (icnt == iwait);
        imem_rdata = rom[imem_addr[11:2]];
        icnt       = imem_ack ? 0 : icnt + 1;
      end else begin
        icnt       = 0;
        imem_ack   = stray_en & tog;
        imem_rdata = 32'hdeadbeef;
      end
      if (dmem_req) begin
        dmem_ack   = (dcnt == dwait);
        dmem_rdata = dram[dmem_addr[11:3]];
        if (dmem_ack && dmem_we) dram[dmem_addr[11:3]] = dmem_wdata;
        dcnt       = dmem_ack ? 0 : dcnt + 1;
      end else begin
        dcnt       = 0;
        dmem_ack   = stray_en & ~tog;
        dmem_rdata = 64'hbad0_bad0_bad0_bad0;
      end
    end
  end

  // -------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tbl[$];
  int cyc = 0;
  int last_fetch = 0;

  task automatic ev(input int kind, input logic [11:0] addr, input logic [63:0] data);
    tbl.push_back({2'(kind), addr, data});
  endtask

  initial begin
    int          dhold;
    logic [11:0] cap_addr;
    logic [63:0] cap_wdata;
    logic        cap_we;
    logic [W-1:0] e, got;
    dhold = 0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        dhold = 0;
        continue;
      end
      if (imem_req && imem_ack) begin
        got = {2'd0, imem_addr, 64'(cyc - last_fetch)};
        if (exp_q.size() == 0) chk(1'b0, "unexpected_fetch", 128'(got), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk(e[77:76] == 2'd0 && e[75:64] == imem_addr &&
              (e[63:0] == 64'd0 || e[63:0] == 64'(cyc - last_fetch)),
              "fetch", 128'(got), 128'(e));
        end
        last_fetch = cyc;
      end
      if (dmem_req) begin
        dhold++;
        if (dhold == 1) begin
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_we = dmem_we;
        end
        if (dmem_ack) begin
          got = {(dmem_we ? 2'd1 : 2'd2), dmem_addr, (dmem_we ? dmem_wdata : 64'd0)};
          if (exp_q.size() == 0) chk(1'b0, "unexpected_dmem", 128'(got), 128'(0));
          else begin
            e = exp_q.pop_front();
            chk({8'(dhold), got} == {8'(dwait + 1), e}, dmem_we ? "store" : "load",
                {42'd0, 8'(dhold), got}, {42'd0, 8'(dwait + 1), e});
          end
          chk({cap_we, cap_addr, cap_wdata} == {dmem_we, dmem_addr, dmem_wdata},
              "dmem_stable", 128'({dmem_we, dmem_addr, dmem_wdata}),
              128'({cap_we, cap_addr, cap_wdata}));
          dhold = 0;
        end
      end else begin
        dhold = 0;
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  // Called at negedge+2: asserts reset immediately, releases it two cycles later.
  task automatic do_reset();
    stray_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk({imem_req, dmem_req, dmem_we, halt, imem_addr} == {4'b0000, 12'h040},
        "reset_outputs", 128'({imem_req, dmem_req, dmem_we, halt, imem_addr}),
        128'({4'b0000, 12'h040}));
`ifdef CORE_MC_PERF_EN
    chk({perf_cycle, perf_instret} == 128'd0, "perf_reset",
        {perf_cycle, perf_instret}, 128'd0);
`endif
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    #1;
    chk({imem_req, dmem_req, halt, imem_addr} == {3'b100, 12'h040}, "release_fetch",
        128'({imem_req, dmem_req, halt, imem_addr}), 128'({3'b100, 12'h040}));
  endtask

  task automatic wait_halt(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (halt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(1'b0, "halt_timeout", 128'(halt), 128'(1));
    else chk(cyc - last_fetch == 2, "halt_timing", 128'(cyc - last_fetch), 128'(2));
  endtask

  task automatic idle_check();
    repeat (20) @(negedge clk);
    #2;
    chk({imem_req, dmem_req, halt} == 3'b001, "halted_idle",
        128'({imem_req, dmem_req, halt}), 128'(3'b001));
  endtask

  task automatic put(input logic [11:0] pc, input logic [31:0] w);
    rom[pc[11:2]] = w;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    bit found;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    for (int i = 0; i < 512; i++) dram[i] = 64'h0;

    put(12'h040, enc_i(5, 0, 0, 1, 7'h13));     // addi x1,x0,5
    put(12'h044, enc_i(-3, 0, 0, 2, 7'h13));    // addi x2,x0,-3
    put(12'h048, enc_r(0, 2, 1, 0, 3));         // add  x3,x1,x2
    put(12'h04C, enc_r(32, 2, 1, 0, 4));        // sub  x4,x1,x2
    put(12'h050, enc_s(8, 1, 0));               // sd   x1,8(x0)
    put(12'h054, enc_i(8, 0, 3, 5, 7'h03));     // ld   x5,8(x0)
    put(12'h058, enc_s(16, 5, 0));              // sd   x5,16(x0)
    put(12'h05C, enc_s(24, 3, 0));              // sd   x3,24(x0)
    put(12'h060, enc_s(32, 4, 0));              // sd   x4,32(x0)
    put(12'h064, enc_i(7, 0, 0, 0, 7'h13));     // addi x0,x0,7
    put(12'h068, enc_s(40, 0, 0));              // sd   x0,40(x0)
    put(12'h06C, enc_r(0, 2, 1, 7, 6));         // and  x6,x1,x2
    put(12'h070, enc_r(0, 2, 1, 6, 7));         // or   x7,x1,x2
    put(12'h074, enc_r(0, 1, 1, 1, 8));         // sll  x8,x1,x1
    put(12'h078, enc_r(0, 1, 2, 5, 9));         // srl  x9,x2,x1
    put(12'h07C, enc_i(63, 0, 0, 11, 7'h13));   // addi x11,x0,63
    put(12'h080, enc_r(0, 11, 1, 1, 10));       // sll  x10,x1,x11
    put(12'h084, enc_s(48, 6, 0));              // sd   x6,48(x0)
    put(12'h088, enc_s(56, 7, 0));              // sd   x7,56(x0)
    put(12'h08C, enc_s(64, 8, 0));              // sd   x8,64(x0)
    put(12'h090, enc_s(72, 9, 0));              // sd   x9,72(x0)
    put(12'h094, enc_s(80, 10, 0));             // sd   x10,80(x0)
    put(12'h098, enc_b(-136, 0, 0));            // beq  x0,x0 -> 0x010
    put(12'h010, enc_b(-8, 1, 1));              // beq  x1,x1,-8 -> 0x008
    put(12'h008, enc_b(16, 1, 2));              // beq  x1,x2,+16 not taken -> 0x00C
    put(12'h00C, enc_b(-16, 0, 0));             // beq  -> 0xFFC (wraps below 0)
    put(12'hFFC, enc_b(8, 0, 0));               // beq  +8 -> 0x004 (wraps past top)
    put(12'h004, 32'h0000007F);                 // illegal opcode

    // kind 0 = fetch (data = cycles since previous fetch, 0 = unchecked),
    // kind 1 = store (data = wdata), kind 2 = load
    ev(0, 12'h040, 0); ev(0, 12'h044, 4); ev(0, 12'h048, 4); ev(0, 12'h04C, 4);
    ev(0, 12'h050, 4); ev(1, 12'h008, 64'd5);
    ev(0, 12'h054, 6); ev(2, 12'h008, 0);
    ev(0, 12'h058, 7); ev(1, 12'h010, 64'd5);
    ev(0, 12'h05C, 6); ev(1, 12'h018, 64'd2);
    ev(0, 12'h060, 6); ev(1, 12'h020, 64'd8);
    ev(0, 12'h064, 6); ev(0, 12'h068, 4); ev(1, 12'h028, 64'd0);
    ev(0, 12'h06C, 6); ev(0, 12'h070, 4); ev(0, 12'h074, 4); ev(0, 12'h078, 4);
    ev(0, 12'h07C, 4); ev(0, 12'h080, 4); ev(0, 12'h084, 4);
    ev(1, 12'h030, 64'd5);
    ev(0, 12'h088, 6); ev(1, 12'h038, 64'hFFFF_FFFF_FFFF_FFFD);
    ev(0, 12'h08C, 6); ev(1, 12'h040, 64'd160);
    ev(0, 12'h090, 6); ev(1, 12'h048, 64'h07FF_FFFF_FFFF_FFFF);
    ev(0, 12'h094, 6); ev(1, 12'h050, 64'h8000_0000_0000_0000);
    ev(0, 12'h098, 6); ev(0, 12'h010, 3); ev(0, 12'h008, 3); ev(0, 12'h00C, 3);
    ev(0, 12'hFFC, 3); ev(0, 12'h004, 3);

    // Phase 1: full program, zero-wait fetch, two data wait states, stray acks.
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    @(negedge clk); #2;
    do_reset();
    @(negedge clk); #3;
    stray_en = 1'b1;
    wait_halt(600);
    chk(exp_q.size() == 0, "queue_drained", 128'(exp_q.size()), 128'(0));
    idle_check();
`ifdef CORE_MC_PERF_EN
    chk(perf_instret == 64'd27, "perf_instret", 128'(perf_instret), 128'd27);
    chk(perf_cycle == 64'd129, "perf_cycle", 128'(perf_cycle), 128'd129);
`endif

    // Phase 2: reset out of HALT, then reset again in the middle of the first store.
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(tbl[i]);
    @(negedge clk); #2;
    do_reset();
    @(negedge clk); #3;
    stray_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (dmem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk(found && {dmem_we, dmem_addr, dmem_wdata} == {1'b1, 12'h008, 64'd5}, "mem_drive",
        128'({found, dmem_we, dmem_addr, dmem_wdata}), 128'({1'b1, 1'b1, 12'h008, 64'd5}));
    chk(exp_q.size() == 0, "pre_abort_queue", 128'(exp_q.size()), 128'(0));
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    do_reset();
    @(negedge clk); #3;
    stray_en = 1'b1;
    wait_halt(600);
    chk(exp_q.size() == 0, "queue_drained2", 128'(exp_q.size()), 128'(0));
    idle_check();

    // ------------------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
